xmint_mem_arbiter: RTL and testbench

Shares the single core-side memory port of the xmint subsystem between the instruction-fetch requester and the load/store requester. It arbitrates requests, holds the winner's address phase stable until the device grants it, and tracks ownership of outstanding transactions so that each response returns to the host that issued it. It sits between the core's `instr_*`/`data_*` buses and the unified memory/interconnect port.

---
 rtl/xmint_pkg.sv | 24 ++
 rtl/xmint_owner_fifo.sv | 59 +++++
 rtl/xmint_mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_xmint_mem_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/xmint_pkg.sv
// xmint_pkg -- shared types for the xmint memory arbiter.
//   arb_owner_e : which host owns a transaction (instruction fetch / load-store)
//   arb_state_e : arbiter FSM states
//   XMINT_BE_FULL : byte-enable pattern driven for instruction fetches
package xmint_pkg;

  typedef enum logic [0:0] {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic [3:0] XMINT_BE_FULL = 4'hF;

  // Index width for a storage of 'depth' entries, never below 1 bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/xmint_owner_fifo.sv
// xmint_owner_fifo -- DEPTH-deep, 1-bit-wide synchronous FIFO of transaction
// owners. Push and pop in the same cycle leave the count unchanged.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (empties FIFO)
//   push_i, data_i      write owner at tail
//   pop_i               drop head entry
//   head_o              owner at head
//   full_o, empty_o     occupancy flags
module xmint_owner_fifo
  import xmint_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  arb_owner_e data_i,
  input  logic       pop_i,
  output arb_owner_e head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_i) rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = arb_owner_e'(mem_q[rd_q]);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/xmint_mem_arbiter.sv
// xmint_mem_arbiter -- shares one core-side memory port between the
// instruction-fetch host (instr_*) and the load/store host (data_*).
// Arbitrates requests, locks the winner's address phase until the device
// grants it, and routes each in-order response back to its issuing host.
// Build option: XMINT_ARB_ROUND_ROBIN_EN -- two-way round-robin on ties;
// when undefined, data always beats instruction.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   instr_req/addr_i, instr_gnt_o     fetch address phase
//   instr_rvalid/rdata/err_o          fetch response
//   data_req/we/be/addr/wdata_i       load/store address phase
//   data_gnt/rvalid/rdata/err_o       load/store grant and response
//   dev_req/we/be/addr/wdata_o        device address phase
//   dev_gnt/rvalid/rdata/err_i        device grant and response
//   spurious_rsp_o                    registered pulse: response with nothing outstanding
module xmint_mem_arbiter
  import xmint_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        dev_req_o,
  output logic        dev_we_o,
  output logic [3:0]  dev_be_o,
  output logic [31:0] dev_addr_o,
  output logic [31:0] dev_wdata_o,
  input  logic        dev_gnt_i,
  input  logic        dev_rvalid_i,
  input  logic        dev_err_i,
  input  logic [31:0] dev_rdata_i,
  output logic        spurious_rsp_o
);

  arb_state_e state_q, state_d;
  arb_owner_e hold_owner_q, hold_owner_d;
  arb_owner_e winner, tie_winner, sel_owner, head_owner;
  logic       fifo_full, fifo_empty;
  logic       req_active, push, pop;
  logic       spurious_q, spurious_d;

  // ---------------- priority ----------------
`ifdef XMINT_ARB_ROUND_ROBIN_EN
  arb_owner_e last_q;

  // Reset to instruction so data wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i)     last_q <= OWNER_INSTR;
    else if (push) last_q <= sel_owner;
  end

  assign tie_winner = (last_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
`else
  assign tie_winner = OWNER_DATA;
`endif

  always_comb begin
    winner = OWNER_INSTR;
    if (instr_req_i && data_req_i) winner = tie_winner;
    else if (data_req_i)           winner = OWNER_DATA;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      hold_owner_q <= OWNER_INSTR;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_owner_q <= hold_owner_d;
      spurious_q   <= spurious_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // A full FIFO blocks new arbitration in IDLE even if a response pops this
  // cycle; HOLD was entered with a free slot so it never needs the check.
  always_comb begin
    state_d      = state_q;
    hold_owner_d = hold_owner_q;
    req_active   = 1'b0;
    sel_owner    = winner;
    if (!rst_i) begin
      case (state_q)
        ARB_IDLE: begin
          req_active = !fifo_full && (instr_req_i || data_req_i);
          if (req_active && !dev_gnt_i) begin
            state_d      = ARB_HOLD;
            hold_owner_d = winner;
          end
        end
        ARB_HOLD: begin
          req_active = 1'b1;
          sel_owner  = hold_owner_q;
          if (dev_gnt_i) state_d = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign push = req_active && dev_gnt_i;
  // A response in the grant cycle belongs to older entries, so pop reads the
  // head before this cycle's push lands.
  assign pop        = !rst_i && dev_rvalid_i && !fifo_empty;
  assign spurious_d = !rst_i && dev_rvalid_i && fifo_empty;

  // ---------------- FSM: outputs ----------------
  always_comb begin
    dev_req_o      = req_active;
    dev_we_o       = 1'b0;
    dev_be_o       = '0;
    dev_addr_o     = '0;
    dev_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    data_rdata_o   = '0;
    if (req_active) begin
      if (sel_owner == OWNER_DATA) begin
        dev_we_o    = data_we_i;
        dev_be_o    = data_be_i;
        dev_addr_o  = data_addr_i;
        dev_wdata_o = data_wdata_i;
        data_gnt_o  = dev_gnt_i;
      end else begin
        dev_be_o    = XMINT_BE_FULL;
        dev_addr_o  = instr_addr_i;
        instr_gnt_o = dev_gnt_i;
      end
    end
    if (pop) begin
      if (head_owner == OWNER_DATA) begin
        data_rvalid_o = 1'b1;
        data_err_o    = dev_err_i;
        data_rdata_o  = dev_rdata_i;
      end else begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = dev_err_i;
        instr_rdata_o  = dev_rdata_i;
      end
    end
  end

  assign spurious_rsp_o = spurious_q;

  // ---------------- ownership tracking ----------------
  xmint_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (sel_owner),
    .pop_i   (pop),
    .head_o  (head_owner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_xmint_mem_arbiter.sv
module tb_xmint_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        dev_req, dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_gnt, dev_rvalid, dev_err;
  logic [31:0] dev_rdata;
  logic        spurious;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  xmint_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_err_o(instr_err), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_err_o(data_err), .data_rdata_o(data_rdata),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be),
    .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
    .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err),
    .dev_rdata_i(dev_rdata), .spurious_rsp_o(spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; checks follow 1ns later.
  task automatic drive(input logic ir, input logic dr, input logic g,
                       input logic rv, input logic er, input logic [31:0] rd);
    @(negedge clk);
    instr_req = ir; data_req = dr; dev_gnt = g;
    dev_rvalid = rv; dev_err = er; dev_rdata = rd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    instr_req = 0; instr_addr = 32'h100;
    data_req = 0; data_we = 1'b1; data_be = 4'h3;
    data_addr = 32'h200; data_wdata = 32'h55;
    dev_gnt = 0; dev_rvalid = 0; dev_err = 0; dev_rdata = 0;

    // Reset: combinational paths gated while reset is high
    drive(1, 1, 1, 1, 0, 32'h1);
    chk("rst_dev_req", 32'(dev_req), 0);
    chk("rst_instr_gnt", 32'(instr_gnt), 0);
    chk("rst_data_rvalid", 32'(data_rvalid), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_spurious", 32'(spurious), 0);
    rst = 1'b0;

    // Single fetch
    drive(1, 0, 1, 0, 0, 0);
    chk("fetch_gnt", 32'(instr_gnt), 1);
    chk("fetch_dev_req", 32'(dev_req), 1);
    chk("fetch_be", 32'(dev_be), 32'hF);
    chk("fetch_addr", dev_addr, 32'h100);
    chk("fetch_wdata", dev_wdata, 0);
    chk("fetch_data_gnt", 32'(data_gnt), 0);
    drive(0, 0, 0, 1, 0, 32'hDEADBEEF);
    chk("fetch_rvalid", 32'(instr_rvalid), 1);
    chk("fetch_rdata", instr_rdata, 32'hDEADBEEF);
    chk("fetch_data_rvalid", 32'(data_rvalid), 0);
    chk("fetch_data_rdata", data_rdata, 0);

    // Tie: four consecutive granted cycles, responses keep the FIFO draining
    for (int i = 0; i < 4; i++) begin
      logic exp_data;
`ifdef XMINT_ARB_ROUND_ROBIN_EN
      exp_data = (i % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      drive(1, 1, 1, (i != 0), 0, 0);
      chk($sformatf("tie%0d_data_gnt", i), 32'(data_gnt), 32'(exp_data));
      chk($sformatf("tie%0d_instr_gnt", i), 32'(instr_gnt), 32'(!exp_data));
      chk($sformatf("tie%0d_addr", i), dev_addr, exp_data ? 32'h200 : 32'h100);
    end
    drive(0, 0, 0, 1, 0, 0);   // drain last entry
    drive(0, 0, 0, 0, 0, 0);

    // Hold: data wins (RR last-granted is instr), device stalls 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      chk($sformatf("hold%0d_req", i), 32'(dev_req), 1);
      chk($sformatf("hold%0d_addr", i), dev_addr, 32'h200);
      chk($sformatf("hold%0d_instr_gnt", i), 32'(instr_gnt), 0);
    end
    drive(1, 1, 1, 0, 0, 0);
    chk("hold_data_gnt", 32'(data_gnt), 1);
    chk("hold_instr_gnt", 32'(instr_gnt), 0);
    chk("hold_we", 32'(dev_we), 1);
    chk("hold_be", 32'(dev_be), 32'h3);
    chk("hold_wdata", dev_wdata, 32'h55);
    drive(0, 0, 0, 1, 0, 32'hA5A5);
    chk("hold_rsp_data", 32'(data_rvalid), 1);
    chk("hold_rsp_rdata", data_rdata, 32'hA5A5);

    // Backpressure + ordering/errors: instr then data outstanding
    drive(1, 0, 1, 0, 0, 0);
    chk("bp_g1", 32'(instr_gnt), 1);
    drive(0, 1, 1, 0, 0, 0);
    chk("bp_g2", 32'(data_gnt), 1);
    drive(1, 1, 1, 0, 0, 0);
    chk("bp_full_req", 32'(dev_req), 0);
    chk("bp_full_gnt", 32'({instr_gnt, data_gnt}), 0);
    drive(1, 1, 1, 1, 1, 32'h11);
    chk("bp_pop_req", 32'(dev_req), 0);
    chk("ord_instr_rvalid", 32'(instr_rvalid), 1);
    chk("ord_instr_err", 32'(instr_err), 1);
    chk("ord_data_rvalid0", 32'(data_rvalid), 0);
    drive(1, 1, 0, 1, 0, 32'h1234);
    chk("bp_rearb_req", 32'(dev_req), 1);
    chk("ord_data_rvalid", 32'(data_rvalid), 1);
    chk("ord_data_err", 32'(data_err), 0);
    chk("ord_data_rdata", data_rdata, 32'h1234);
    chk("ord_instr_rvalid0", 32'(instr_rvalid), 0);
`ifdef XMINT_ARB_ROUND_ROBIN_EN
    chk("bp_rearb_addr", dev_addr, 32'h100);
    drive(1, 1, 1, 0, 0, 0);
    chk("bp_rearb_gnt", 32'(instr_gnt), 1);
    drive(0, 0, 0, 1, 0, 32'h77);
    chk("bp_rearb_rsp", 32'(instr_rvalid), 1);
`else
    chk("bp_rearb_addr", dev_addr, 32'h200);
    drive(1, 1, 1, 0, 0, 0);
    chk("bp_rearb_gnt", 32'(data_gnt), 1);
    drive(0, 0, 0, 1, 0, 32'h77);
    chk("bp_rearb_rsp", 32'(data_rvalid), 1);
`endif

    // Spurious response with empty FIFO
    drive(0, 0, 0, 1, 0, 32'h99);
    chk("sp_no_instr", 32'(instr_rvalid), 0);
    chk("sp_no_data", 32'(data_rvalid), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("sp_pulse", 32'(spurious), 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("sp_clear", 32'(spurious), 0);

    // Reset with two outstanding, then a stale response
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    instr_req = 0; data_req = 0; dev_gnt = 0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 32'hBAD);
    chk("rst_stale_instr", 32'(instr_rvalid), 0);
    chk("rst_stale_data", 32'(data_rvalid), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_stale_spurious", 32'(spurious), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
